// File: rtl/neural_compressor_pkg.sv
// Shared types and constants for the neural compressor output framer.
// Holds the framer FSM state type, the HDR0 layout, the frame sync nibble
// and the CRC-16-CCITT constants plus a word-wide CRC update helper.
package neural_compressor_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int USER_WIDTH = 2;

  localparam logic [3:0]  FRAME_SYNC = 4'hA;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_TRAILER = 3'd4
  } framer_state_t;

  typedef struct packed {
    logic [3:0] sync;
    logic [3:0] chan;
    logic [7:0] len;
  } frame_hdr0_t;

  // CRC-16-CCITT over one 16-bit word, MSB first, no reflection.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                             input logic [15:0] word);
    logic [15:0] crc_v;
    logic        fb_v;
    crc_v = crc_in;
    for (int i = 15; i >= 0; i--) begin
      fb_v  = crc_v[15] ^ word[i];
      crc_v = {crc_v[14:0], 1'b0};
      if (fb_v) begin
        crc_v = crc_v ^ CRC16_POLY;
      end else begin
        crc_v = crc_v;
      end
    end
    return crc_v;
  endfunction

endpackage

// File: rtl/framer_checksum.sv
// Running frame checksum for neural_packet_framer.
// Build option FRAMER_CRC_EN: defined -> CRC-16-CCITT (init 0xFFFF);
// undefined -> 16-bit modular sum (init 0x0000).
// clear restarts the checksum; clear together with valid folds the word
// into a fresh checksum so the first header word needs no extra cycle.
module framer_checksum
  import neural_compressor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        valid,
  input  logic [15:0] word,
  output logic [15:0] csum
);

`ifdef FRAMER_CRC_EN
  localparam logic [15:0] CSUM_INIT = CRC16_INIT;
`else
  localparam logic [15:0] CSUM_INIT = 16'h0000;
`endif

  logic [15:0] csum_r;
  logic [15:0] base_s;
  logic [15:0] next_s;

  // Next checksum value from the (possibly restarted) running value and the word.
  always_comb begin
    if (clear) begin
      base_s = CSUM_INIT;
    end else begin
      base_s = csum_r;
    end
`ifdef FRAMER_CRC_EN
    next_s = crc16_word(base_s, word);
`else
    next_s = base_s + word;
`endif
  end

  // Checksum register: fold a word on valid, restart on a bare clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_r <= CSUM_INIT;
    end else if (valid) begin
      csum_r <= next_s;
    end else if (clear) begin
      csum_r <= CSUM_INIT;
    end else begin
      csum_r <= csum_r;
    end
  end

  assign csum = csum_r;

endmodule

// File: rtl/neural_packet_framer.sv
// neural_packet_framer: collects compressed AXI-Stream words into frames and
// emits HDR0, HDR1, payload, TRAILER. Collection and emission never overlap.
// Build option FRAMER_CRC_EN selects a CRC-16-CCITT trailer instead of the
// default 16-bit modular sum (see framer_checksum).
module neural_packet_framer
  import neural_compressor_pkg::*;
#(
  parameter int MAX_PAYLOAD  = 64,
  parameter int IDLE_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic [3:0]            cfg_channel_id,
  input  logic                  cfg_enable,
  output logic [15:0]           frame_count,
  output logic                  timeout_flush
);

  localparam int PTR_W  = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int DEPTH  = 1 << PTR_W;
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [7:0]        MAX_LEN   = 8'(MAX_PAYLOAD);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  framer_state_t     state_r;
  logic [17:0]       buf_r [DEPTH];
  logic [7:0]        len_r;
  logic [7:0]        rd_ptr_r;
  logic [IDLE_W-1:0] idle_r;
  logic [15:0]       seq_r;
  logic [15:0]       frame_count_r;
  logic [15:0]       m_tdata_r;
  logic [1:0]        m_tuser_r;
  logic              m_tvalid_r;
  logic              m_tlast_r;
  logic              timeout_flush_r;

  logic          tready_s;
  logic          accept_s;
  logic          hs_s;
  logic          close_s;
  logic          timeout_s;
  logic          done_s;
  logic [7:0]    len_inc_s;
  logic [17:0]   rd_entry_s;
  frame_hdr0_t   hdr0_s;
  framer_state_t state_nxt_s;
  logic [7:0]    rd_ptr_nxt_s;
  logic          load_s;
  logic [15:0]   load_data_s;
  logic [1:0]    load_user_s;
  logic          load_last_s;
  logic          csum_clear_s;
  logic          csum_valid_s;
  logic [15:0]   csum_s;

  assign tready_s   = (state_r == ST_COLLECT) && cfg_enable;
  assign accept_s   = tready_s && s_axis_tvalid;
  assign hs_s       = m_tvalid_r && m_axis_tready;
  assign done_s     = (state_r == ST_TRAILER) && hs_s;
  assign len_inc_s  = len_r + 8'd1;
  assign rd_entry_s = buf_r[rd_ptr_r[PTR_W-1:0]];

  // Frame close decision: closing beat, full buffer, or idle timeout.
  always_comb begin
    close_s   = 1'b0;
    timeout_s = 1'b0;
    if (state_r == ST_COLLECT) begin
      if (accept_s) begin
        close_s = s_axis_tlast || (len_inc_s == MAX_LEN);
      end else if ((len_r != 8'd0) && (idle_r == IDLE_LAST)) begin
        close_s   = 1'b1;
        timeout_s = 1'b1;
      end else begin
        close_s   = 1'b0;
        timeout_s = 1'b0;
      end
    end else begin
      close_s   = 1'b0;
      timeout_s = 1'b0;
    end
  end

  // HDR0 contents; the length includes a beat accepted in the closing cycle.
  always_comb begin
    hdr0_s.sync = FRAME_SYNC;
    hdr0_s.chan = cfg_channel_id;
    if (accept_s) begin
      hdr0_s.len = len_inc_s;
    end else begin
      hdr0_s.len = len_r;
    end
  end

  // Next output beat: each word is loaded into the output register on the
  // handshake of the previous one and folded into the checksum as it is
  // loaded, so the trailer is already complete when it is needed.
  always_comb begin
    state_nxt_s  = state_r;
    rd_ptr_nxt_s = rd_ptr_r;
    load_s       = 1'b0;
    load_data_s  = 16'h0000;
    load_user_s  = 2'b00;
    load_last_s  = 1'b0;
    csum_clear_s = 1'b0;
    csum_valid_s = 1'b0;
    case (state_r)
      ST_COLLECT: begin
        rd_ptr_nxt_s = 8'd0;
        if (close_s) begin
          state_nxt_s  = ST_HDR0;
          load_s       = 1'b1;
          load_data_s  = hdr0_s;
          csum_clear_s = 1'b1;
          csum_valid_s = 1'b1;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_HDR0: begin
        if (hs_s) begin
          state_nxt_s  = ST_HDR1;
          load_s       = 1'b1;
          load_data_s  = seq_r;
          csum_valid_s = 1'b1;
        end else begin
          state_nxt_s = ST_HDR0;
        end
      end
      ST_HDR1, ST_PAYLOAD: begin
        if (hs_s && (state_r == ST_PAYLOAD) && (rd_ptr_r == len_r)) begin
          state_nxt_s = ST_TRAILER;
          load_s      = 1'b1;
          load_data_s = csum_s;
          load_last_s = 1'b1;
        end else if (hs_s) begin
          state_nxt_s  = ST_PAYLOAD;
          load_s       = 1'b1;
          load_data_s  = rd_entry_s[15:0];
          load_user_s  = rd_entry_s[17:16];
          rd_ptr_nxt_s = rd_ptr_r + 8'd1;
          csum_valid_s = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_TRAILER: begin
        if (hs_s) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_TRAILER;
        end
      end
      default: begin
        state_nxt_s = ST_COLLECT;
      end
    endcase
  end

  // Payload buffer write; storage needs no reset since len_r gates reads.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      buf_r[len_r[PTR_W-1:0]] <= {s_axis_tuser, s_axis_tdata};
    end
  end

  // Framer FSM with registered output beat, counters and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_COLLECT;
      len_r           <= 8'd0;
      rd_ptr_r        <= 8'd0;
      idle_r          <= {IDLE_W{1'b0}};
      seq_r           <= 16'h0000;
      frame_count_r   <= 16'h0000;
      m_tdata_r       <= 16'h0000;
      m_tuser_r       <= 2'b00;
      m_tvalid_r      <= 1'b0;
      m_tlast_r       <= 1'b0;
      timeout_flush_r <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      rd_ptr_r        <= rd_ptr_nxt_s;
      timeout_flush_r <= timeout_s;

      if (load_s) begin
        m_tvalid_r <= 1'b1;
        m_tdata_r  <= load_data_s;
        m_tuser_r  <= load_user_s;
        m_tlast_r  <= load_last_s;
      end else if (done_s) begin
        m_tvalid_r <= 1'b0;
        m_tdata_r  <= 16'h0000;
        m_tuser_r  <= 2'b00;
        m_tlast_r  <= 1'b0;
      end else begin
        m_tvalid_r <= m_tvalid_r;
      end

      if (state_r == ST_COLLECT) begin
        if (accept_s) begin
          len_r <= len_inc_s;
        end else begin
          len_r <= len_r;
        end
        if (accept_s || close_s || (len_r == 8'd0)) begin
          idle_r <= {IDLE_W{1'b0}};
        end else begin
          idle_r <= idle_r + IDLE_W'(1);
        end
      end else if (done_s) begin
        len_r  <= 8'd0;
        idle_r <= {IDLE_W{1'b0}};
      end else begin
        len_r  <= len_r;
        idle_r <= {IDLE_W{1'b0}};
      end

      if (done_s) begin
        seq_r         <= seq_r + 16'd1;
        frame_count_r <= frame_count_r + 16'd1;
      end else begin
        seq_r         <= seq_r;
        frame_count_r <= frame_count_r;
      end
    end
  end

  framer_checksum u_checksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (csum_clear_s),
    .valid (csum_valid_s),
    .word  (load_data_s),
    .csum  (csum_s)
  );

  assign s_axis_tready = tready_s;
  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tuser  = m_tuser_r;
  assign m_axis_tvalid = m_tvalid_r;
  assign m_axis_tlast  = m_tlast_r;
  assign frame_count   = frame_count_r;
  assign timeout_flush = timeout_flush_r;

endmodule

// File: tb/tb_neural_packet_framer.sv
// Randomized self-checking bench for neural_packet_framer. A queue-based
// reference model turns accepted input beats into expected frames and
// compares every output handshake; honours FRAMER_CRC_EN for the trailer.
module tb_neural_packet_framer;

  localparam int MAXP = 64;
  localparam int IDLE = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_axis_tdata;
  logic [1:0]  s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [3:0]  cfg_channel_id;
  logic        cfg_enable;
  logic [15:0] frame_count;
  logic        timeout_flush;

  neural_packet_framer #(.MAX_PAYLOAD(MAXP), .IDLE_TIMEOUT(IDLE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .cfg_channel_id (cfg_channel_id),
    .cfg_enable     (cfg_enable),
    .frame_count    (frame_count),
    .timeout_flush  (timeout_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  user;
    logic        last;
    int          kind;   // 0 HDR0, 1 HDR1, 2 payload, 3 trailer
  } beat_t;

  beat_t       exp_q[$];
  logic [17:0] cur_q[$];
  logic [15:0] hdr0_log[$];
  logic [15:0] hdr1_log[$];
  logic [15:0] trl_log[$];
  beat_t       mon_b;
  int          idle_cnt;
  int          seq_m;
  int          frames_m;
  int          tf_seen;
  logic        exp_tf;
  bit          mon_en;
  int          rdy_mode;
  logic        stall_p;
  logic [18:0] stall_v;
  int          n_vec;
  int          n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference trailer computed straight from the word list.
  function automatic logic [15:0] ref_csum(input logic [15:0] w[$]);
    int acc;
`ifdef FRAMER_CRC_EN
    int fb;
    acc = 32'hFFFF;
    foreach (w[k]) begin
      for (int b = 15; b >= 0; b--) begin
        fb  = ((acc >> 15) & 1) ^ ((w[k] >> b) & 1);
        acc = (acc << 1) & 32'hFFFF;
        if (fb != 0) acc = acc ^ 32'h1021;
      end
    end
`else
    acc = 0;
    foreach (w[k]) acc = (acc + int'(w[k])) % 65536;
`endif
    return acc[15:0];
  endfunction

  function automatic void close_frame(input bit by_timeout);
    logic [15:0] words[$];
    beat_t b;
    words.push_back({4'hA, cfg_channel_id, 8'(cur_q.size())});
    words.push_back(16'(seq_m));
    foreach (cur_q[k]) words.push_back(cur_q[k][15:0]);
    foreach (words[k]) begin
      b.data = words[k];
      b.user = (k >= 2) ? cur_q[k-2][17:16] : 2'b00;
      b.last = 1'b0;
      b.kind = (k == 0) ? 0 : ((k == 1) ? 1 : 2);
      exp_q.push_back(b);
    end
    b.data = ref_csum(words);
    b.user = 2'b00;
    b.last = 1'b1;
    b.kind = 3;
    exp_q.push_back(b);
    seq_m    = (seq_m + 1) % 65536;
    idle_cnt = 0;
    cur_q.delete();
    exp_tf   = by_timeout;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    cur_q.delete();
    seq_m    = 0;
    frames_m = 0;
    idle_cnt = 0;
    exp_tf   = 1'b0;
    stall_p  = 1'b0;
  endfunction

  // Monitor: at each negedge, decide what the coming posedge will transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("timeout_flush", timeout_flush, exp_tf);
      exp_tf = 1'b0;
      if (timeout_flush) tf_seen++;
      if (stall_p) begin
        check_eq("stall_valid", m_axis_tvalid, 1);
        check_eq("stall_beat", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, stall_v);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        stall_p = 1'b0;
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 1, 0);
        end else begin
          mon_b = exp_q.pop_front();
          check_eq("out_data", m_axis_tdata, mon_b.data);
          check_eq("out_user", m_axis_tuser, mon_b.user);
          check_eq("out_last", m_axis_tlast, mon_b.last);
          case (mon_b.kind)
            0: hdr0_log.push_back(m_axis_tdata);
            1: hdr1_log.push_back(m_axis_tdata);
            3: begin trl_log.push_back(m_axis_tdata); frames_m++; end
            default: ;
          endcase
        end
      end else if (m_axis_tvalid) begin
        stall_p = 1'b1;
        stall_v = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
      end else begin
        stall_p = 1'b0;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        cur_q.push_back({s_axis_tuser, s_axis_tdata});
        idle_cnt = 0;
        if (s_axis_tlast || cur_q.size() == MAXP) close_frame(1'b0);
      end else if (cur_q.size() > 0) begin
        idle_cnt++;
        if (idle_cnt == IDLE) close_frame(1'b1);
      end
    end
  end

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 1) == 1);
      default: m_axis_tready = 1'b0;
    endcase
  end

  task automatic send(input logic [15:0] d, input logic [1:0] u, input logic l);
    int n;
    bit ok;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 4000) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check_eq("send_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && cur_q.size() == 0 && !m_axis_tvalid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) check_eq("drain_timeout", 0, 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] wq[$];
  logic [15:0] exp_trl;
  int          flen;
  int          h0_before;

  initial begin
    n_vec = 0; n_err = 0; tf_seen = 0;
    mon_en = 1'b0; rdy_mode = 0; m_axis_tready = 1'b1;
    s_axis_tdata = 16'h0000; s_axis_tuser = 2'b00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cfg_channel_id = 4'h0; cfg_enable = 1'b1;
    model_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tdata", m_axis_tdata, 0);
    check_eq("rst_tuser", m_axis_tuser, 0);
    check_eq("rst_tlast", m_axis_tlast, 0);
    check_eq("rst_frame_count", frame_count, 0);
    check_eq("rst_timeout_flush", timeout_flush, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    wait_cycles(1);
    check_eq("collect_tready", s_axis_tready, 1);

    // Basic framing, channel 5, three beats.
    cfg_channel_id = 4'd5;
    send(16'h0001, 2'd1, 1'b0);
    send(16'h0002, 2'd2, 1'b0);
    send(16'h0003, 2'd3, 1'b1);
    drain();
    wq = {16'hA503, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
`ifdef FRAMER_CRC_EN
    exp_trl = ref_csum(wq);
`else
    exp_trl = 16'hA509;
`endif
    check_eq("frame1_hdr0", hdr0_log[hdr0_log.size()-1], 16'hA503);
    check_eq("frame1_hdr1", hdr1_log[hdr1_log.size()-1], 16'h0000);
    check_eq("frame1_trailer", trl_log[trl_log.size()-1], exp_trl);
    check_eq("frame1_count", frame_count, 1);

    // Full buffer: 64 beats close the frame, the 65th waits for the next one.
    for (int i = 0; i < MAXP; i++) send(16'h0100 + 16'(i), 2'($urandom_range(0, 3)), 1'b0);
    check_eq("full_tready", s_axis_tready, 0);
    send(16'h0BEE, 2'd2, 1'b1);
    drain();
    check_eq("full_hdr0", hdr0_log[hdr0_log.size()-2], 16'hA540);
    check_eq("overflow_hdr0", hdr0_log[hdr0_log.size()-1], 16'hA501);
    check_eq("overflow_seq", hdr1_log[hdr1_log.size()-1], 16'h0002);

    // Idle timeout flush of a two-word frame.
    tf_seen = 0;
    h0_before = hdr0_log.size();
    send(16'h1111, 2'd0, 1'b0);
    send(16'h2222, 2'd1, 1'b0);
    wait_cycles(200);
    check_eq("no_early_flush", tf_seen, 0);
    check_eq("no_early_hdr", hdr0_log.size(), h0_before);
    drain();
    check_eq("timeout_pulses", tf_seen, 1);
    check_eq("timeout_hdr0", hdr0_log[hdr0_log.size()-1], 16'hA502);

    // Randomized backpressure over 20 input frames.
    rdy_mode = 1;
    for (int f = 0; f < 20; f++) begin
      cfg_channel_id = 4'($urandom_range(0, 15));
      flen = $urandom_range(1, 70);
      for (int k = 0; k < flen; k++) begin
        send(16'($urandom()), 2'($urandom_range(0, 3)), (k == flen - 1));
        if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 3));
      end
    end
    drain();
    rdy_mode = 0;
    check_eq("bp_frame_count", frame_count, frames_m);

    // cfg_enable drop with a partial frame pending: timeout still flushes it.
    cfg_channel_id = 4'd7;
    send(16'hAAAA, 2'd1, 1'b0);
    send(16'hBBBB, 2'd2, 1'b0);
    send(16'hCCCC, 2'd3, 1'b0);
    cfg_enable = 1'b0;
    wait_cycles(1);
    check_eq("disabled_tready", s_axis_tready, 0);
    drain();
    check_eq("disabled_hdr0", hdr0_log[hdr0_log.size()-1], 16'hA703);
    cfg_enable = 1'b1;

    // Single word 0x1234 on channel 0: trailer checked against a constant or CRC golden.
    cfg_channel_id = 4'd0;
    send(16'h1234, 2'd0, 1'b1);
    drain();
    wq = {16'hA001, hdr1_log[hdr1_log.size()-1], 16'h1234};
`ifdef FRAMER_CRC_EN
    wq[1] = hdr1_log[hdr1_log.size()-1];
    exp_trl = ref_csum(wq);
`else
    exp_trl = 16'hA001 + 16'h1234 + 16'(seq_m - 1);
`endif
    check_eq("single_hdr0", hdr0_log[hdr0_log.size()-1], 16'hA001);
    check_eq("single_trailer", trl_log[trl_log.size()-1], exp_trl);

    // Reset while emitting payload.
    cfg_channel_id = 4'd3;
    for (int k = 0; k < 10; k++) send(16'h0500 + 16'(k), 2'd1, (k == 9));
    wait_cycles(3);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_eq("abort_tvalid", m_axis_tvalid, 0);
    check_eq("abort_tdata", m_axis_tdata, 0);
    check_eq("abort_tuser", m_axis_tuser, 0);
    check_eq("abort_tlast", m_axis_tlast, 0);
    check_eq("abort_frame_count", frame_count, 0);
    check_eq("abort_timeout_flush", timeout_flush, 0);
    model_reset();
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    mon_en = 1'b1;
    send(16'h55AA, 2'd1, 1'b1);
    drain();
    check_eq("post_reset_seq", hdr1_log[hdr1_log.size()-1], 16'h0000);
    check_eq("post_reset_count", frame_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
